// File: rtl/double_dabble_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// Ports: clk, rst (async high), in_valid/in_ready/in_data, out_valid/out_ready/out_bcd/out_overflow.

module double_dabble_cell (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    assign corrected = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

module double_dabble_converter #(
    parameter int BINARY_WIDTH = 16,
    parameter int DIGIT_COUNT  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BINARY_WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*DIGIT_COUNT-1:0]  out_bcd,
    output logic                      out_overflow
);

    localparam int BW = 4 * DIGIT_COUNT;
    localparam int CW = $clog2(BINARY_WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(BINARY_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                       load;
    logic                       step;
    logic [BINARY_WIDTH-1:0]    bin_q;
    logic [BW-1:0]              bcd_q;
    logic [BW-1:0]              bcd_corr;
    logic [CW-1:0]              cnt_q;
    logic                       ovf_q;
    logic [BW+BINARY_WIDTH-1:0] shifted;

    for (genvar i = 0; i < DIGIT_COUNT; i++) begin : g_cell
        double_dabble_cell u_cell (
            .digit     (bcd_q[4*i +: 4]),
            .corrected (bcd_corr[4*i +: 4])
        );
    end

    // Top bit of the corrected BCD falls off here; it is the overflow carry.
    assign shifted = {bcd_corr, bin_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            bin_q <= in_data;
            bcd_q <= '0;
            cnt_q <= CNT_INIT;
            ovf_q <= 1'b0;
        end else if (step) begin
            bcd_q <= shifted[BW+BINARY_WIDTH-1:BINARY_WIDTH];
            bin_q <= shifted[BINARY_WIDTH-1:0];
            cnt_q <= cnt_q - CNT_ONE;
            ovf_q <= ovf_q | bcd_corr[BW-1];
        end
    end

    assign out_bcd      = bcd_q;
    assign out_overflow = ovf_q;

endmodule
